reaction_game_score_display_ctrl: RTL

//  Sequences the seven-segment datapath for the reaction-time readout.
//  - Accepts a binary reaction time on a load pulse.
//  - Converts it to BCD iteratively (shift-add-3, one bit per cycle).
//  - Commits the digits and per-digit enables that feed one REACTION_GAME_DIGIT2HEX instance per digit.
//  - Blanks leading zeros and provides blink and saturate-on-overflow display modes.

---
 rtl/reaction_game_pkg.sv | 12 +
 rtl/reaction_game_bin2bcd_seq.sv | 46 ++++
 rtl/reaction_game_score_display_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/reaction_game_pkg.sv
// reaction_game_pkg: shared state encoding, BCD constants and display range helper
package reaction_game_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} disp_state_t;
  localparam int BCD_W = 4;
  localparam logic [3:0] DIGIT_NINE = 4'h9;
  function automatic int max_val(input int n);
    int m;
    m = 1;
    for (int i = 0; i < n; i++) m = m * 10;
    return m - 1;
  endfunction
endpackage

// File: rtl/reaction_game_bin2bcd_seq.sv
// reaction_game_bin2bcd_seq: iterative shift-add-3 binary to BCD converter, one bit per cycle
module reaction_game_bin2bcd_seq
  import reaction_game_pkg::*;
#(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin,
  output logic [BCD_W*NUM_DIGITS-1:0] bcd,
  output logic                        last
);
  localparam int DW = BCD_W * NUM_DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  logic [BIN_W-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [DW-1:0]    adj;
  // Digits above NUM_DIGITS are dropped; carries only move upward so the kept nibbles stay exact
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[BCD_W*i +: BCD_W] = (bcd[BCD_W*i +: BCD_W] >= 4'd5) ? bcd[BCD_W*i +: BCD_W] + 4'd3 : bcd[BCD_W*i +: BCD_W];
    last = active && (cnt == CW'(BIN_W - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sr     <= bin;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      sr     <= sr << 1;
      bcd    <= {adj[DW-2:0], sr[BIN_W-1]};
      cnt    <= cnt + 1'b1;
      active <= !last;
    end
  end
endmodule

// File: rtl/reaction_game_score_display_ctrl.sv
// reaction_game_score_display_ctrl: sequences BCD conversion, commit, leading-zero blanking and blink for the score display
module reaction_game_score_display_ctrl
  import reaction_game_pkg::*;
#(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BIN_W-1:0]            value,
  input  logic                        blink,
  input  logic                        blank_all,
  output logic [BCD_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);
  localparam int DW = BCD_W * NUM_DIGITS;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [31:0] MAX_V = 32'(max_val(NUM_DIGITS));
  disp_state_t           state, state_d;
  logic                  start, last, ovf_pend, phase;
  logic [DW-1:0]         bcd;
  logic [CW-1:0]         blink_cnt;
  logic [NUM_DIGITS-1:0] lz_mask;
  reaction_game_bin2bcd_seq #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (value),
    .bcd   (bcd),
    .last  (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  always_comb begin
    start   = (state == IDLE) && load;
    busy    = state == CONVERT;
    done    = state == COMMIT;
    state_d = start ? CONVERT : (busy && last) ? COMMIT : done ? IDLE : state;
  end
  // Committed outputs change only in COMMIT, so the display never shows partial conversions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend <= 1'b0;
      digits   <= '0;
      overflow <= 1'b0;
    end else begin
      if (start) ovf_pend <= 32'(value) > MAX_V;
      if (done) begin
        digits   <= ovf_pend ? {NUM_DIGITS{DIGIT_NINE}} : bcd;
        overflow <= ovf_pend;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (!blink) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
  always_comb begin
    lz_mask    = '0;
    lz_mask[0] = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) lz_mask[i] = |(digits >> (BCD_W * i));
  end
  // Dropping blink overrides a pending dark phase at once so enables follow within one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) digit_en <= '0;
    else        digit_en <= (!blank_all && (phase || !blink)) ? lz_mask : '0;
endmodule
